// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer: power wait, PRECHARGE ALL, AUTO REFRESH burst,
// LOAD MODE, then holds init_end until a re-initialisation request arrives.
module sdram_init_ctrl #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned T_POWER   = 10000,
   parameter int unsigned T_RP      = 2,
   parameter int unsigned T_RFC     = 7,
   parameter int unsigned T_MRD     = 3,
   parameter int unsigned AREF_NUM  = 8,
   parameter int unsigned CAS_LAT   = 3,
   parameter int unsigned BURST_LEN = 512
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              init_req,
   output logic [3:0]        init_cmd,
   output logic [1:0]        init_ba,
   output logic [ADDR_W-1:0] init_addr,
   output logic              init_end
);

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_LMR  = 4'b0000;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] PRE  = 3'd1;
   localparam logic [2:0] TRP  = 3'd2;
   localparam logic [2:0] AREF = 3'd3;
   localparam logic [2:0] TRF  = 3'd4;
   localparam logic [2:0] MRS  = 3'd5;
   localparam logic [2:0] TMRD = 3'd6;
   localparam logic [2:0] END  = 3'd7;

   localparam int unsigned T_MAX_A = (T_POWER > T_RFC) ? T_POWER : T_RFC;
   localparam int unsigned T_MAX_B = (T_RP > T_MRD) ? T_RP : T_MRD;
   localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
   localparam int unsigned CNT_W   = (T_MAX > 2) ? $clog2(T_MAX) : 1;

   // Wait states end on the last count value, so each lasts T_x-1 cycles.
   localparam logic [CNT_W-1:0] CNT_POWER = CNT_W'(T_POWER - 1);
   localparam logic [CNT_W-1:0] CNT_RP    = CNT_W'(T_RP - 2);
   localparam logic [CNT_W-1:0] CNT_RFC   = CNT_W'(T_RFC - 2);
   localparam logic [CNT_W-1:0] CNT_MRD   = CNT_W'(T_MRD - 2);
   localparam logic [3:0]       AREF_LIM  = 4'(AREF_NUM);

   localparam logic [2:0] BL_CODE = (BURST_LEN == 1) ? 3'b000 :
                                    (BURST_LEN == 2) ? 3'b001 :
                                    (BURST_LEN == 4) ? 3'b010 :
                                    (BURST_LEN == 8) ? 3'b011 : 3'b111;

   // A9 write burst, A8:A7 standard, A6:A4 CAS, A3 sequential, A2:A0 burst length.
   localparam logic [ADDR_W-1:0] MODE_WORD =
      {{(ADDR_W-10){1'b0}}, 1'b0, 2'b00, 3'(CAS_LAT), 1'b0, BL_CODE};

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        aref_cnt_q, aref_cnt_d;
   logic [3:0]        cmd_d;
   logic [1:0]        ba_d;
   logic [ADDR_W-1:0] addr_d;
   logic              end_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cnt_q == CNT_POWER) state_d = PRE;
         PRE:     state_d = TRP;
         TRP:     if (cnt_q == CNT_RP) state_d = AREF;
         AREF:    state_d = TRF;
         TRF:     if (cnt_q == CNT_RFC) state_d = (aref_cnt_q < AREF_LIM) ? AREF : MRS;
         MRS:     state_d = TMRD;
         TMRD:    if (cnt_q == CNT_MRD) state_d = END;
         END:     if (init_req) state_d = PRE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q == {CNT_W{1'b1}}) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      aref_cnt_d = aref_cnt_q;
      if (state_d == PRE) begin
         aref_cnt_d = '0;
      end else if (state_q == AREF) begin
         aref_cnt_d = aref_cnt_q + 4'd1;
      end
   end

   // Outputs are decoded from the next state so they line up with the registered state.
   always_comb begin
      cmd_d  = CMD_NOP;
      ba_d   = 2'b11;
      addr_d = '1;
      end_d  = 1'b0;
      case (state_d)
         PRE:  cmd_d = CMD_PRE;
         AREF: cmd_d = CMD_AREF;
         MRS: begin
            cmd_d  = CMD_LMR;
            ba_d   = 2'b00;
            addr_d = MODE_WORD;
         end
         END:     end_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         aref_cnt_q <= '0;
         init_cmd   <= CMD_NOP;
         init_ba    <= 2'b11;
         init_addr  <= '1;
         init_end   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         aref_cnt_q <= aref_cnt_d;
         init_cmd   <= cmd_d;
         init_ba    <= ba_d;
         init_addr  <= addr_d;
         init_end   <= end_d;
      end
   end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Self-checking bench for sdram_init_ctrl: default build plus a 13-bit-address build,
// compared each cycle against a timeline model of the init sequence.
module tb_sdram_init_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_req = 1'b0;
   logic [3:0]  a_cmd, b_cmd;
   logic [1:0]  a_ba, b_ba;
   logic [11:0] a_addr;
   logic [12:0] b_addr;
   logic        a_end, b_end;

   always #5 clk = ~clk;

   sdram_init_ctrl dut_a (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .init_req  (init_req),
      .init_cmd  (a_cmd),
      .init_ba   (a_ba),
      .init_addr (a_addr),
      .init_end  (a_end)
   );

   sdram_init_ctrl #(
      .ADDR_W    (13),
      .T_POWER   (20),
      .AREF_NUM  (2),
      .CAS_LAT   (2),
      .BURST_LEN (4)
   ) dut_b (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .init_req  (init_req),
      .init_cmd  (b_cmd),
      .init_ba   (b_ba),
      .init_addr (b_addr),
      .init_end  (b_end)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Configuration of the two builds, in the order dut_a, dut_b.
   int t_rp     = 2;
   int t_rfc    = 7;
   int t_mrd    = 3;
   int pow_p[2] = '{10000, 20};
   int nref[2]  = '{8, 2};
   int cas[2]   = '{3, 2};
   int blen[2]  = '{512, 4};

   // Model: mode 0 = reset/power wait (cnt = edges since release), 1 = sequence (cnt = offset).
   int m_mode[2];
   int m_cnt[2];

   int cyc;
   int first_pre[2], first_mrs[2], first_end[2], aref_seen[2], end_hi[2];
   logic [12:0] mrs_addr[2];

   function automatic int bl_code(input int bl);
      case (bl)
         1:       return 0;
         2:       return 1;
         4:       return 2;
         8:       return 3;
         default: return 7;
      endcase
   endfunction

   function automatic int seq_len(input int i);
      return t_rp + nref[i] * t_rfc + t_mrd;
   endfunction

   function automatic logic [19:0] expect_out(input int i);
      logic [12:0] ones;
      logic [12:0] mw;
      int          o;
      int          mrs_o;
      ones  = (i == 1) ? 13'h1FFF : 13'h0FFF;
      mw    = 13'(cas[i] * 16 + bl_code(blen[i]));
      o     = m_cnt[i];
      mrs_o = t_rp + nref[i] * t_rfc;
      if (m_mode[i] == 0) return {4'b0111, 2'b11, ones, 1'b0};
      if (o == 0) return {4'b0010, 2'b11, ones, 1'b0};
      if (o >= t_rp && o < mrs_o && ((o - t_rp) % t_rfc) == 0)
         return {4'b0001, 2'b11, ones, 1'b0};
      if (o == mrs_o) return {4'b0000, 2'b00, mw, 1'b0};
      if (o >= seq_len(i)) return {4'b0111, 2'b11, ones, 1'b1};
      return {4'b0111, 2'b11, ones, 1'b0};
   endfunction

   function automatic logic [19:0] obs_out(input int i);
      if (i == 0) return {a_cmd, a_ba, 1'b0, a_addr, a_end};
      return {b_cmd, b_ba, b_addr, b_end};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0;
         m_cnt[i]  = 0;
      end
   endtask

   task automatic model_adv();
      for (int i = 0; i < 2; i++) begin
         if (m_mode[i] == 0) begin
            m_cnt[i]++;
            if (m_cnt[i] >= pow_p[i]) begin
               m_mode[i] = 1;
               m_cnt[i]  = 0;
            end
         end else if (m_cnt[i] >= seq_len(i)) begin
            if (init_req) m_cnt[i] = 0;
         end else begin
            m_cnt[i]++;
         end
      end
   endtask

   task automatic track_reset();
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
         first_pre[i] = -1;
         first_mrs[i] = -1;
         first_end[i] = -1;
         aref_seen[i] = 0;
         end_hi[i]    = 0;
         mrs_addr[i]  = '0;
      end
   endtask

   task automatic step();
      logic [19:0] o;
      @(posedge clk);
      if (rst_n) model_adv();
      cyc++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         o = obs_out(i);
         check($sformatf("out%0d_c%0d", i, cyc), 32'(o), 32'(expect_out(i)));
         if (o[19:16] == 4'b0010 && first_pre[i] < 0) first_pre[i] = cyc;
         if (o[19:16] == 4'b0001 && first_end[i] < 0) aref_seen[i]++;
         if (o[19:16] == 4'b0000 && first_mrs[i] < 0) begin
            first_mrs[i] = cyc;
            mrs_addr[i]  = o[13:1];
         end
         if (o[0]) begin
            end_hi[i]++;
            if (first_end[i] < 0) first_end[i] = cyc;
         end
      end
   endtask

   // Called at a falling edge; outputs must go to the reset pattern without a clock.
   task automatic pulse_reset(input int low_cycles);
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++)
         check($sformatf("rst_async%0d", i), 32'(obs_out(i)), 32'(expect_out(i)));
      repeat (low_cycles) step();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      track_reset();
      repeat (3) step();
      rst_n = 1'b1;
      track_reset();

      // Default timeline from reset release.
      repeat (10070) step();
      check("a_pre", first_pre[0], 10000);
      check("a_aref_cnt", aref_seen[0], 8);
      check("a_mrs", first_mrs[0], 10058);
      check("a_mrs_addr", 32'(mrs_addr[0]), 32'h037);
      check("a_end", first_end[0], 10061);
      check("b_pre", first_pre[1], 20);
      check("b_aref_cnt", aref_seen[1], 2);
      check("b_mrs", first_mrs[1], 36);
      check("b_mrs_addr", 32'(mrs_addr[1]), 32'h0022);
      check("b_end", first_end[1], 39);

      // Random re-initialisation requests.
      repeat (3000) begin
         init_req = ($urandom_range(0, 7) == 0);
         step();
      end
      init_req = 1'b0;

      // Reset between the 3rd and 4th AUTO REFRESH, then a clean full run.
      pulse_reset(2);
      track_reset();
      repeat (10016 + $urandom_range(1, 6)) step();
      check("a_aref_before_rst", aref_seen[0], 3);
      pulse_reset($urandom_range(1, 4));
      track_reset();
      repeat (10070) step();
      check("a_pre_after_rst", first_pre[0], 10000);
      check("a_aref_after_rst", aref_seen[0], 8);
      check("a_end_after_rst", first_end[0], 10061);

      // Single-cycle request in END: no power wait.
      init_req = 1'b1;
      track_reset();
      step();
      init_req = 1'b0;
      repeat (70) step();
      check("a_reinit_pre", first_pre[0], 1);
      check("a_reinit_end", first_end[0], 62);
      check("b_reinit_end", first_end[1], 20);

      // Request held from reset: back-to-back sequences, one END cycle each.
      init_req = 1'b1;
      pulse_reset(2);
      track_reset();
      repeat (400) step();
      check("b_held_end_first", first_end[1], 39);
      check("b_held_end_cycles", end_hi[1], 19);
      init_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_init_ctrl.md
SDRAM_INIT_CTRL -- requirements
Module: sdram_init_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12: SDRAM address bus width; minimum 11.
REQ-002 Parameter T_POWER, default 10000: power-up wait in clocks (200 us at 50 MHz).
REQ-003 Parameter T_RP, default 2: PRECHARGE-to-next-command spacing in clocks; minimum 2.
REQ-004 Parameter T_RFC, default 7: AUTO REFRESH-to-next-command spacing in clocks; minimum 2.
REQ-005 Parameter T_MRD, default 3: LOAD MODE-to-init_end spacing in clocks; minimum 2.
REQ-006 Parameter AREF_NUM, default 8: number of AUTO REFRESH commands in the sequence; range 1..15.
REQ-007 Parameter CAS_LAT, default 3: CAS latency programmed into the mode register; legal values 2 and 3.
REQ-008 Parameter BURST_LEN, default 512: burst length; 1, 2, 4 or 8; any other value selects full page.
REQ-009 sys_clk  input  1  sole clock; all logic on the rising edge.
REQ-010 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-011 init_req  input  1  re-initialisation request; sampled only in state END.
REQ-012 init_cmd  output  4  {cs_n, ras_n, cas_n, we_n}.
REQ-013 init_ba  output  2  bank address.
REQ-014 init_addr  output  ADDR_W  address / mode word.
REQ-015 init_end  output  1  high while initialisation is complete.

Function
REQ-016 Command codes: NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001, LOAD MODE 4'b0000.
REQ-017 All outputs are registered, with states IDLE, PRE, TRP, AREF, TRF, MRS, TMRD and END.
- IDLE: a cycle counter advances; IDLE -> PRE when the counter reaches T_POWER-1.
- PRE: issues PRECHARGE for one cycle, then -> TRP.
- TRP: lasts T_RP-1 cycles, then -> AREF.
- AREF: issues AUTO REFRESH for one cycle, increments aref_cnt, then -> TRF.
- TRF: lasts T_RFC-1 cycles, then -> AREF if aref_cnt < AREF_NUM, else -> MRS.
- MRS: issues LOAD MODE for one cycle, then -> TMRD.
- TMRD: lasts T_MRD-1 cycles, then -> END.
REQ-018 Outside the PRE, AREF and MRS states, init_cmd is NOP, init_ba is 2'b11 and init_addr is all ones.
REQ-019 During PRECHARGE, init_ba is 2'b11 and init_addr is all ones (A10=1 selects all banks).
REQ-020 During LOAD MODE, init_ba is 2'b00 and init_addr is the mode word zero-extended to ADDR_W.
- A9=0: burst write.
- A8:A7=00.
- A6:A4 = CAS_LAT.
- A3=0: sequential.
- A2:A0: 000 for burst length 1, 001 for 2, 010 for 4, 011 for 8, 111 for full page.
REQ-021 Consecutive commands are separated by exactly T_RP, T_RFC or T_MRD clocks, counted edge to edge.
REQ-022 init_end rises exactly T_MRD clocks after the LOAD MODE cycle.
- init_end stays high while the state is END.
- In END, init_cmd is NOP.
REQ-023 The cycle counter clears on every state change.
- The counter saturates and does not wrap.
- aref_cnt clears on entry to PRE.
REQ-024 In END, init_req=1 on a clock edge selects PRE for the next cycle and deasserts init_end in that same cycle.
- A re-initialisation skips the T_POWER wait.
- It repeats the full PRE/AREF/MRS sequence.
REQ-025 init_req is ignored in every state other than END.
- A request held high through END causes back-to-back re-initialisations.

Reset
REQ-026 While sys_rst_n=0, regardless of current state, the block forces the following:
- state IDLE.
- Counters 0.
- init_cmd NOP, init_ba 2'b11, init_addr all ones.
- init_end 0.
REQ-027 Reset release starts the T_POWER wait from counter 0.
- Reset asserted mid-sequence abandons the sequence with no partial command completed.

Verification
REQ-028 Defaults, reset released at cycle 0: PRECHARGE at cycle 10000; AUTO REFRESH at 10002, 10009, ... 10051 (8 total); LOAD MODE at 10058 with init_addr=12'h037; init_end=1 from cycle 10061.
REQ-029 CAS_LAT=2, BURST_LEN=4, AREF_NUM=2, T_POWER=20: PRECHARGE at cycle 20; AUTO REFRESH at 22 and 29; LOAD MODE at 36 with addr=12'h022; init_end at 39.
REQ-030 Reset pulsed low between the 3rd and 4th AUTO REFRESH -> outputs immediately NOP/0; after release, PRECHARGE again after T_POWER cycles; aref_cnt restarts at 0 (8 refreshes seen).
REQ-031 init_req pulsed for 1 cycle in END -> init_end low next cycle; PRECHARGE that same cycle; no T_POWER wait; full sequence; init_end high again 61 cycles after the request edge.
REQ-032 init_req held high from reset through END -> ignored until END; then repeated sequences; init_end high for exactly 1 cycle each time.
REQ-033 ADDR_W=13 -> mode word in init_addr[12:0] with A12=0; all-ones pattern 13'h1FFF during PRECHARGE/NOP.
